// File: rtl/sfx_scheduler_pkg.sv
// Shared music definitions: scheduler FSM encoding, default state codes and
// small priority helpers.
package sfx_scheduler_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StPlay = 2'd2
    } sfx_fsm_e;

    localparam logic [3:0] BgStateDefault   = 4'd0;
    localparam logic [3:0] SfxState0Default = 4'd1;
    localparam logic [3:0] SfxState1Default = 4'd2;
    localparam logic [3:0] SfxState2Default = 4'd3;
    localparam logic [3:0] SfxState3Default = 4'd4;
    localparam logic [7:0] DurDefault       = 8'd8;

    // Index 0 wins.
    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        logic [1:0] idx;
        if (v[0]) begin
            idx = 2'd0;
        end else if (v[1]) begin
            idx = 2'd1;
        end else if (v[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    function automatic logic [3:0] idx_onehot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

endpackage

// File: rtl/sfx_scheduler_tick_gen.sv
// Beat tick divider: pulses tick once every TICK_DIV cycles after clear drops.
module tick_gen #(
    parameter int unsigned TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned W = $clog2(TICK_DIV);
    localparam logic [W-1:0] Last = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q;

    assign tick = (cnt_q == Last);

    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: arbitrates one-cycle effect requests over the
// background music theme and drives a tone generator with registered outputs.
module sfx_scheduler
    import sfx_scheduler_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 12_500_000,
    parameter logic [3:0]  BG_STATE   = BgStateDefault,
    parameter logic [3:0]  SFX_STATE0 = SfxState0Default,
    parameter logic [3:0]  SFX_STATE1 = SfxState1Default,
    parameter logic [3:0]  SFX_STATE2 = SfxState2Default,
    parameter logic [3:0]  SFX_STATE3 = SfxState3Default,
    parameter logic [7:0]  DUR0       = DurDefault,
    parameter logic [7:0]  DUR1       = DurDefault,
    parameter logic [7:0]  DUR2       = DurDefault,
    parameter logic [7:0]  DUR3       = DurDefault
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] req,
    input  logic [1:0] pitch_in,
    output logic [3:0] state,
    output logic [1:0] pitch,
    output logic       music_rst,
    output logic [3:0] grant,
    output logic       busy,
    output logic       done
);

    sfx_fsm_e   fsm_q, fsm_d;
    logic [3:0] pending_q, pending_d;
    logic [1:0] cur_q, cur_d;
    logic [7:0] tick_cnt_q, tick_cnt_d;
    logic [3:0] state_q, state_d;
    logic [1:0] pitch_q, pitch_d;
    logic [3:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic       music_rst_q, music_rst_d;
    logic       done_q, done_d;

    logic       tick;
    logic       tick_clear;
    logic       load;
    logic       finish;
    logic [1:0] win;
    logic       any_pending;

    function automatic logic [3:0] sfx_code(input logic [1:0] i);
        logic [3:0] code;
        unique case (i)
            2'd0:    code = SFX_STATE0;
            2'd1:    code = SFX_STATE1;
            2'd2:    code = SFX_STATE2;
            default: code = SFX_STATE3;
        endcase
        return code;
    endfunction

    function automatic logic [7:0] dur_of(input logic [1:0] i);
        logic [7:0] dur;
        unique case (i)
            2'd0:    dur = DUR0;
            2'd1:    dur = DUR1;
            2'd2:    dur = DUR2;
            default: dur = DUR3;
        endcase
        return dur;
    endfunction

    // Divider held at zero outside PLAY, so the k-th tick lands k*TICK_DIV after LOAD.
    assign tick_clear = (fsm_q != StPlay);

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .clear(tick_clear),
        .tick (tick)
    );

    assign win         = lowest_idx(pending_q);
    assign any_pending = |pending_q;

    always_comb begin
        fsm_d       = fsm_q;
        cur_d       = cur_q;
        pending_d   = pending_q;
        tick_cnt_d  = tick_cnt_q;
        state_d     = state_q;
        pitch_d     = pitch_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        music_rst_d = 1'b0;
        done_d      = 1'b0;
        load        = 1'b0;
        finish      = 1'b0;

        unique case (fsm_q)
            StIdle: begin
                if (any_pending) begin
                    fsm_d = StLoad;
                    load  = 1'b1;
                end
            end
            StLoad: fsm_d = StPlay;
            StPlay: begin
                if (tick && (tick_cnt_q == dur_of(cur_q) - 8'd1)) begin
                    finish = 1'b1;
                    if (any_pending) begin
                        fsm_d = StLoad;
                        load  = 1'b1;
                    end else begin
                        fsm_d = StIdle;
                    end
                end else if (any_pending && (win < cur_q)) begin
                    fsm_d = StLoad;
                    load  = 1'b1;
                end
            end
            default: fsm_d = StIdle;
        endcase

        if (fsm_q == StLoad) begin
            tick_cnt_d = '0;
        end else if ((fsm_q == StPlay) && tick) begin
            tick_cnt_d = tick_cnt_q + 8'd1;
        end

        if (load) begin
            pending_d[win] = 1'b0;
            cur_d          = win;
            state_d        = sfx_code(win);
            pitch_d        = pitch_in;
            grant_d        = idx_onehot(win);
            busy_d         = 1'b1;
            music_rst_d    = 1'b1;
        end else if ((fsm_d == StIdle) && (fsm_q != StIdle)) begin
            state_d     = BG_STATE;
            grant_d     = '0;
            busy_d      = 1'b0;
            music_rst_d = 1'b1;
        end

        done_d    = finish;
        // A new request beats the clear of the index being loaded.
        pending_d = pending_d | req;

        if (!enable) begin
            fsm_d       = StIdle;
            cur_d       = cur_q;
            pending_d   = '0;
            tick_cnt_d  = '0;
            state_d     = BG_STATE;
            pitch_d     = pitch_q;
            grant_d     = '0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            music_rst_d = (fsm_q != StIdle);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q       <= StIdle;
            cur_q       <= '0;
            pending_q   <= '0;
            tick_cnt_q  <= '0;
            state_q     <= BG_STATE;
            pitch_q     <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            music_rst_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            cur_q       <= cur_d;
            pending_q   <= pending_d;
            tick_cnt_q  <= tick_cnt_d;
            state_q     <= state_d;
            pitch_q     <= pitch_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            music_rst_q <= music_rst_d;
            done_q      <= done_d;
        end
    end

    assign state     = state_q;
    assign pitch     = pitch_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign music_rst = music_rst_q;
    assign done      = done_q;

endmodule

// File: doc/sfx_scheduler.md
SFX_SCHEDULER -- requirements
Module: sfx_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 12_500_000, clk cycles per beat tick (0.125 s at 100 MHz); legal range 2 or greater.
REQ-002 Parameter BG_STATE, default 4'd0, music state for the background theme.
REQ-003 Parameters SFX_STATE0..SFX_STATE3, defaults 4'd1..4'd4, music state per requester.
REQ-004 Parameters DUR0..DUR3, default 8'd8, playback length per requester, in ticks; legal range 1 to 255.
REQ-005 clk  input  1  single system clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  scheduler enable; low forces background.
REQ-008 req  input  4  one-cycle sound-effect request pulses; index 0 has highest priority.
REQ-009 pitch_in  input  2  pitch selection, sampled at grant.
REQ-010 state  output  4  music state to the tone generator.
REQ-011 pitch  output  2  pitch to the tone generator.
REQ-012 music_rst  output  1  one-cycle pulse restarting the tone generator's beat counter.
REQ-013 grant  output  4  one-hot current requester; 0 when background.
REQ-014 busy  output  1  high while a sound effect is active.
REQ-015 done  output  1  one-cycle pulse on natural completion of a sound effect.

Function
REQ-016 pending[i] SHALL be set on req[i] and cleared when i is loaded; set wins over a simultaneous clear.
REQ-017 FSM states SHALL be IDLE, LOAD and PLAY.
REQ-018 IDLE with any pending bit SHALL go to LOAD, selecting the lowest pending index.
REQ-019 LOAD SHALL last 1 cycle and, in that cycle: drive state=SFX_STATEi, latch pitch=pitch_in, grant=one-hot(i), busy=1, music_rst=1, clear the tick divider and tick count.
REQ-020 A request asserted in cycle n from IDLE SHALL produce the LOAD cycle at n+2.
REQ-021 A tick SHALL occur every TICK_DIV cycles after LOAD; the k-th tick SHALL fall at LOAD+k*TICK_DIV.
REQ-022 PLAY SHALL end on the DURi-th tick.
REQ-023 On the cycle after the DURi-th tick, done SHALL be 1, and then:
- if any bit is pending, the FSM SHALL be in LOAD for the new winner;
- otherwise it SHALL be in IDLE with state=BG_STATE, grant=0, busy=0, music_rst=1.
REQ-024 In PLAY, a pending index strictly lower than the current index SHALL preempt: LOAD follows on the next cycle, done stays 0, and the preempted effect is dropped.
REQ-025 Pending bits of equal or higher index SHALL wait in PLAY.
REQ-026 A req for the currently playing index SHALL queue a replay after completion.
REQ-027 When enable=0, the next cycle SHALL be IDLE with pending cleared, state=BG_STATE, music_rst=1 (only if the FSM was not already IDLE), done=0, and requests ignored.
REQ-028 All outputs SHALL be registered; there SHALL be no combinational path from input to output.
REQ-029 The tick divider SHALL be a ceil(log2(TICK_DIV))-bit counter, and the tick count SHALL be an 8-bit counter that does not wrap within legal DUR values.

Reset
REQ-030 Synchronous reset SHALL force, on the next edge:
- FSM to IDLE, pending=0, counters=0;
- state=BG_STATE, pitch=0, grant=0;
- busy=0, done=0, music_rst=0.
REQ-031 Reset SHALL override enable and req in the same cycle; a reset during PLAY SHALL abort without done.

Structure
REQ-032 The FSM state encoding and the default BG/SFX state codes SHALL live in the shared music package.
REQ-033 The tick divider SHALL be one sub-module, tick_gen (clk, reset, clear, tick), parameterised by TICK_DIV.

Verification (TICK_DIV=4, DUR2=3, DUR3=2, defaults otherwise)
REQ-034 Reset released with no requests -> state=0, grant=0, busy=0, music_rst=0, done=0 held for 50 cycles.
REQ-035 req[2] pulsed at cycle 10 with pitch_in=2 ->
- cycle 12: state=3, pitch=2, grant=4'b0100, music_rst=1;
- ticks at 16, 20 and 24;
- cycle 25: done=1, state=0, music_rst=1, busy=0.
REQ-036 req[1] and req[2] pulsed in the same cycle -> SFX_STATE1 plays first, then SFX_STATE2 begins in the done cycle, with no background cycle between them.
REQ-037 req[3] playing, req[0] pulsed mid-PLAY -> LOAD for index 0 two cycles later, done=0, and index 3 does not resume after index 0 completes.
REQ-038 enable dropped during PLAY with req[1] pending -> next cycle state=0, music_rst=1, busy=0, and index 1 never plays after enable returns.
REQ-039 reset asserted for 1 cycle mid-PLAY -> all outputs at reset values on the next cycle, with no done pulse.
